tdm_demux16: RTL and testbench
==============================

Name: tdm_demux16

Overview:
- Time-division 1-to-16 demultiplexer/deserializer: the receive end of the 16:1 serial scan path.
- Accepts one serial bit per valid cycle, steers it into channel slot 0..15 via an internal slot counter, and presents the completed 16-bit frame as a registered parallel word.
- Sits downstream of the 16:1 mux scanner; resynchronises on a start-of-frame marker.

Parameters:
- N_CH, 16, number of channels per frame (fixed at 16 for this revision).
- SEL_W, 4, slot counter width (log2 N_CH).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- din  input  1  serial data bit
- din_valid  input  1  din is valid this cycle
- sof  input  1  start of frame; qualified by din_valid; marks din as slot 0
- q  output  16  last completed frame; q[k] = bit received in slot k
- slot  output  SEL_W  slot index the next valid bit will be written to
- frame_done  output  1  one-cycle pulse the cycle after q updates
- sync_err  output  1  one-cycle pulse: sof arrived mid-frame
- locked  output  1  high while in RUN

Behaviour:
- Reset (rst_n=0 at clk edge): state=IDLE, q=16'h0000, slot=0, frame_done=0, sync_err=0, locked=0, shadow register=0. Reset mid-frame discards the partial frame.
- States:
  - IDLE: ignore din until din_valid&sof. On that event, write shadow[0]=din, set slot=1, and go to RUN.
  - RUN: each din_valid cycle writes shadow[slot]=din and increments slot.
- Frame completion: on a valid bit with slot==15 (no sof), the cycle's output register load is q <= {din, shadow[14:0]}.
  - slot wraps to 0 and the block stays in RUN, because the upstream scanner is continuous.
  - frame_done=1 on the following cycle. q is stable until the next completion.
- din_valid=0: no write, no slot change, no pulse; gaps of any length are allowed in both states.
- sof while in RUN with slot==0: normal frame start. shadow[0]=din, slot=1, no error.
- sof while in RUN with slot!=0: abort the partial frame.
  - q is unchanged and sync_err pulses next cycle.
  - shadow[0]=din, slot=1, stay in RUN.
- sof coincident with what would be slot 15: treated as an abort. The frame does not complete, frame_done=0, sync_err=1.
- locked=1 exactly when state==RUN.
- Slot arithmetic is unsigned SEL_W-bit modulo 16.
- Shadow writes use a one-hot enable from the slot decoder, gated by din_valid.
- Latency: last bit in -> q valid at next edge -> frame_done the cycle after.

Optional Feature:
- Macro TDM_DEMUX_PARITY_EN.
- When defined, each frame carries a 17th slot (slot==16) holding even parity over the 16 data bits, and the slot counter is SEL_W+1 bits.
  - On the parity slot: if (^shadow ^ din)==0, load q and pulse frame_done. Otherwise leave q unchanged and pulse output parity_err (1 bit, reset 0; port exists only when the macro is defined).
  - The counter wraps 16->0. sof rules apply to slots 1..16.
- When undefined, the frame is 16 slots as above and there is no parity_err port.

Decomposition:
- Shared package tdm_pkg holds:
  - N_CH and SEL_W constants
  - state typedef {IDLE, RUN}
  - PARITY_SLOT constant (16)
- One natural sub-module, dec4to16: combinational slot -> 16-bit one-hot write enable with an enable input (din_valid).
  - Instanced once; the one-hot output is not asserted when the slot is 16 in the parity build.

Test Plan:
- Reset then frame: after reset, drive sof on the first valid bit and send bits of 16'hA5C3 LSB-first, one per cycle -> q=16'hA5C3 one edge after bit 15, frame_done pulses once a cycle later, slot back to 0, locked=1.
- Gapped input: same frame with din_valid low for 3 cycles between every bit -> identical q=16'hA5C3. slot holds during gaps and no extra pulses occur.
- Back-to-back: 16'h1234 then 16'hFFFF continuous, sof only on the first frame -> q=16'h1234 then q=16'hFFFF, two frame_done pulses 16 cycles apart.
- Mid-frame resync: after 7 bits of one frame, assert sof with new frame 16'h00F0 -> sync_err pulses once, q keeps its prior value, then q=16'h00F0 after 16 bits.
- Reset mid-frame: rst_n=0 after 9 bits -> q=0, slot=0, locked=0. A following non-sof bit is ignored (slot stays 0, state IDLE).
- Parity build: frame 16'h0001 with parity bit 1 -> q=16'h0001, frame_done. Same frame with parity bit 0 -> parity_err pulse, q unchanged.

Source files
------------

// File: rtl/tdm_demux16_pkg.sv
// Shared constants and types for the 16-channel TDM deserializer.
// TDM_DEMUX_PARITY_EN adds a 17th parity slot and widens the slot counter.
package tdm_pkg;
   localparam int unsigned N_CH        = 16;
   localparam int unsigned SEL_W       = 4;
   localparam int unsigned PARITY_SLOT = 16;
`ifdef TDM_DEMUX_PARITY_EN
   localparam int unsigned SLOT_W      = SEL_W + 1;
   localparam int unsigned LAST_SLOT   = PARITY_SLOT;
`else
   localparam int unsigned SLOT_W      = SEL_W;
   localparam int unsigned LAST_SLOT   = N_CH - 1;
`endif

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;
endpackage

// File: rtl/tdm_demux16_if.sv
// Serial-in / parallel-out bus between the 16:1 scanner and the deserializer.
// parity_err exists only when TDM_DEMUX_PARITY_EN is defined.
interface tdm_demux16_if;
   import tdm_pkg::*;

   logic              din;
   logic              din_valid;
   logic              sof;
   logic [N_CH-1:0]   q;
   logic [SLOT_W-1:0] slot;
   logic              frame_done;
   logic              sync_err;
   logic              locked;
`ifdef TDM_DEMUX_PARITY_EN
   logic              parity_err;
`endif

   modport master (
      output din, din_valid, sof,
      input  q, slot, frame_done, sync_err, locked
`ifdef TDM_DEMUX_PARITY_EN
      , input parity_err
`endif
   );

   modport slave (
      input  din, din_valid, sof,
      output q, slot, frame_done, sync_err, locked
`ifdef TDM_DEMUX_PARITY_EN
      , output parity_err
`endif
   );
endinterface

// File: rtl/tdm_demux16_dec4to16.sv
// Slot index to one-hot shadow write enable; the parity slot decodes to nothing.
// TDM_DEMUX_PARITY_EN widens the select by one bit.
module dec4to16
   import tdm_pkg::*;
(
   input  logic [SLOT_W-1:0] sel_i,
   input  logic              en_i,
   output logic [N_CH-1:0]   oh_o
);
   logic sel_ok;

`ifdef TDM_DEMUX_PARITY_EN
   assign sel_ok = ~sel_i[SEL_W];
`else
   assign sel_ok = 1'b1;
`endif

   always_comb begin
      oh_o = '0;
      if (en_i && sel_ok) oh_o[sel_i[SEL_W-1:0]] = 1'b1;
   end
endmodule

// File: rtl/tdm_demux16.sv
// 1-to-16 TDM deserializer: steers serial bits into slots, publishes whole frames.
// TDM_DEMUX_PARITY_EN adds an even-parity slot that gates the frame load.
module tdm_demux16
   import tdm_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   tdm_demux16_if.slave   bus
);
   state_t            state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic [N_CH-1:0]   shadow_q, shadow_d;
   logic [N_CH-1:0]   q_q, q_d;
   logic              done_pend_q, done_pend_d;
   logic              frame_done_q;
   logic              sync_err_q, sync_err_d;
   logic              locked_q;
   logic              parity_err_q, parity_err_d;
   logic [SLOT_W-1:0] dec_sel;
   logic              dec_en;
   logic [N_CH-1:0]   we_oh;

   // A start-of-frame bit always lands in slot 0, whatever the counter says.
   assign dec_sel = bus.sof ? '0 : slot_q;
   assign dec_en  = bus.din_valid & ((state_q == RUN) | bus.sof);

   dec4to16 u_dec (
      .sel_i (dec_sel),
      .en_i  (dec_en),
      .oh_o  (we_oh)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (bus.din_valid && bus.sof) state_d = RUN;
   end

   always_comb begin
      slot_d       = slot_q;
      shadow_d     = (shadow_q & ~we_oh) | ({N_CH{bus.din}} & we_oh);
      q_d          = q_q;
      done_pend_d  = 1'b0;
      sync_err_d   = 1'b0;
      parity_err_d = 1'b0;
      if (bus.din_valid) begin
         if (bus.sof) begin
            slot_d     = SLOT_W'(1);
            sync_err_d = (state_q == RUN) && (slot_q != '0);
         end else if (state_q == RUN) begin
            if (slot_q == SLOT_W'(LAST_SLOT)) begin
               slot_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
               if ((^shadow_q ^ bus.din) == 1'b0) begin
                  q_d         = shadow_q;
                  done_pend_d = 1'b1;
               end else begin
                  parity_err_d = 1'b1;
               end
`else
               q_d         = {bus.din, shadow_q[N_CH-2:0]};
               done_pend_d = 1'b1;
`endif
            end else begin
               slot_d = SLOT_W'(slot_q + 1'b1);
            end
         end
      end
   end

   // frame_done trails the q load by one more cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         slot_q       <= '0;
         shadow_q     <= '0;
         q_q          <= '0;
         done_pend_q  <= 1'b0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         locked_q     <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         shadow_q     <= shadow_d;
         q_q          <= q_d;
         done_pend_q  <= done_pend_d;
         frame_done_q <= done_pend_q;
         sync_err_q   <= sync_err_d;
         locked_q     <= (state_d == RUN);
         parity_err_q <= parity_err_d;
      end
   end

   assign bus.q          = q_q;
   assign bus.slot       = slot_q;
   assign bus.frame_done = frame_done_q;
   assign bus.sync_err   = sync_err_q;
   assign bus.locked     = locked_q;
`ifdef TDM_DEMUX_PARITY_EN
   assign bus.parity_err = parity_err_q;
`else
   logic unused_parity;
   assign unused_parity = parity_err_q;
`endif
endmodule

// File: tb/tb_tdm_demux16.sv
// Self-checking bench for tdm_demux16: directed plan frames plus random traffic
// against a queue-based frame model. Honours TDM_DEMUX_PARITY_EN.
module tb_tdm_demux16;
   import tdm_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   failures = 0;

   tdm_demux16_if bus ();

   tdm_demux16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: bits received since the current frame's sof.
   bit          m_bits[$];
   bit          m_locked;
   logic [15:0] m_q;
   bit          m_pend, m_fd, m_se, m_pe;

   function automatic void model_step(input bit r, input bit v, input bit s, input bit d);
      logic [15:0] data;
      bit          par;
      if (!r) begin
         m_bits.delete();
         m_locked = 0; m_q = 16'h0; m_pend = 0; m_fd = 0; m_se = 0; m_pe = 0;
         return;
      end
      m_fd = m_pend; m_pend = 0; m_se = 0; m_pe = 0;
      if (!v) return;
      if (s) begin
         if (m_locked && m_bits.size() != 0) m_se = 1;
         m_locked = 1;
         m_bits.delete();
         m_bits.push_back(d);
      end else if (m_locked) begin
         m_bits.push_back(d);
         if (m_bits.size() == LAST_SLOT + 1) begin
            par = 0;
            for (int k = 0; k < 16; k++) begin
               data[k] = m_bits[k];
               par ^= m_bits[k];
            end
            if (LAST_SLOT == 15 || (par ^ m_bits[m_bits.size()-1]) == 0) begin
               m_q = data; m_pend = 1;
            end else begin
               m_pe = 1;
            end
            m_bits.delete();
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      check("q",          32'(bus.q),          32'(m_q));
      check("slot",       32'(bus.slot),       32'(m_bits.size()));
      check("frame_done", 32'(bus.frame_done), 32'(m_fd));
      check("sync_err",   32'(bus.sync_err),   32'(m_se));
      check("locked",     32'(bus.locked),     32'(m_locked));
`ifdef TDM_DEMUX_PARITY_EN
      check("parity_err", 32'(bus.parity_err), 32'(m_pe));
`endif
   endtask

   task automatic step(input bit v, input bit s, input bit d);
      bus.din_valid = v; bus.sof = s; bus.din = d;
      @(posedge clk);
      model_step(rst_n, v, s, d);
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 1'($urandom), 1'($urandom));
   endtask

   // Send nbits of data LSB-first, gap invalid cycles before each bit.
   task automatic send_bits(input logic [15:0] data, input int nbits, input bit use_sof, input int gap);
      for (int k = 0; k < nbits; k++) begin
         idle(gap);
         step(1, use_sof && k == 0, data[k]);
      end
   endtask

   task automatic send_frame(input logic [15:0] data, input bit use_sof, input int gap, input bit par_ok);
      send_bits(data, 16, use_sof, gap);
`ifdef TDM_DEMUX_PARITY_EN
      idle(gap);
      step(1, 0, (^data) ^ ~par_ok);
`else
      if (!par_ok) $display("note: parity request ignored in 16-slot build");
`endif
   endtask

   initial begin
      logic [15:0] rd;
      int          fd_seen;
      rst_n = 1'b0;
      bus.din = 0; bus.din_valid = 0; bus.sof = 0;
      step(1, 1, 1);
      step(0, 0, 0);
      check("reset_q", 32'(bus.q), 32'h0);
      check("reset_locked", 32'(bus.locked), 32'h0);
      rst_n = 1'b1;

      // Reset then frame; trailing idle exposes frame_done.
      send_frame(16'hA5C3, 1, 0, 1);
      check("a5c3_q", 32'(bus.q), 32'hA5C3);
      check("a5c3_done_not_yet", 32'(bus.frame_done), 32'h0);
      idle(1);
      check("a5c3_done", 32'(bus.frame_done), 32'h1);
      check("a5c3_slot", 32'(bus.slot), 32'h0);
      check("a5c3_locked", 32'(bus.locked), 32'h1);
      idle(2);

      // Gapped input.
      send_frame(16'hA5C3, 1, 3, 1);
      idle(3);
      check("gap_q", 32'(bus.q), 32'hA5C3);

      // Back-to-back, sof only on the first frame.
      send_frame(16'h1234, 1, 0, 1);
      check("b2b_q0", 32'(bus.q), 32'h1234);
      send_frame(16'hFFFF, 0, 0, 1);
      check("b2b_q1", 32'(bus.q), 32'hFFFF);
      idle(2);

      // Mid-frame resync.
      send_bits(16'h5A5A, 7, 1, 0);
      send_bits(16'h00F0, 1, 1, 0);
      idle(1);
      check("resync_q_held", 32'(bus.q), 32'hFFFF);
      send_bits(16'h00F0 >> 1, 15, 0, 0);
`ifdef TDM_DEMUX_PARITY_EN
      step(1, 0, 1'b0);
`endif
      check("resync_q", 32'(bus.q), 32'h00F0);
      idle(2);

      // Abort coincident with slot 15.
      send_bits(16'h7777, 15, 1, 0);
      step(1, 1, 1);
      idle(1);
      check("sof15_q_held", 32'(bus.q), 32'h00F0);

      // Reset mid-frame.
      send_bits(16'hC3C3, 9, 0, 0);
      rst_n = 1'b0;
      step(0, 0, 0);
      rst_n = 1'b1;
      check("rstmid_q", 32'(bus.q), 32'h0);
      check("rstmid_locked", 32'(bus.locked), 32'h0);
      step(1, 0, 1);
      check("rstmid_slot", 32'(bus.slot), 32'h0);
      check("rstmid_idle", 32'(bus.locked), 32'h0);

`ifdef TDM_DEMUX_PARITY_EN
      // Parity slot: good then bad parity.
      send_frame(16'h0001, 1, 0, 1);
      check("par_ok_q", 32'(bus.q), 32'h0001);
      idle(1);
      check("par_ok_done", 32'(bus.frame_done), 32'h1);
      send_frame(16'h0003, 0, 0, 0);
      check("par_bad_err", 32'(bus.parity_err), 32'h1);
      check("par_bad_q", 32'(bus.q), 32'h0001);
      idle(2);
`endif

      // Random traffic: random frames, gaps, occasional aborts and bad parity.
      fd_seen = 0;
      for (int f = 0; f < 24; f++) begin
         rd = 16'($urandom);
         if ($urandom_range(0, 5) == 0)
            send_bits(16'($urandom), $urandom_range(1, 15), 1, $urandom_range(0, 1));
         send_frame(rd, (f == 0) || ($urandom_range(0, 2) == 0),
                    $urandom_range(0, 2), $urandom_range(0, 7) != 0);
         if (bus.frame_done) fd_seen++;
      end
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      failures++;
      $display("FAIL timeout observed=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
